// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and default timing for the entrance gate arbiter
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OPEN      = 2'd1,
    WAIT_PASS = 2'd2,
    CLOSE     = 2'd3
  } gate_state_t;

  typedef enum logic {
    LANE_NORMAL   = 1'b0,
    LANE_HANDICAP = 1'b1
  } lane_t;

  localparam int unsigned DEF_OPEN_CYCLES  = 100_000_000;
  localparam int unsigned DEF_PASS_TIMEOUT = 500_000_000;
  localparam int unsigned DEF_CLOSE_CYCLES = 100_000_000;
  localparam int unsigned DEF_CNT_W        = 30;

  function automatic lane_t other_lane(lane_t l);
    return (l == LANE_NORMAL) ? LANE_HANDICAP : LANE_NORMAL;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// rtl/gate_timer.sv - phase counter with synchronous clear, enable and limit compare
module gate_timer #(
  parameter int unsigned CNT_W = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = (count == limit);

endmodule

// File: rtl/gate_arbiter.sv
// rtl/gate_arbiter.sv - round-robin lane arbiter and open/wait/close sequencer for the shared barrier
module gate_arbiter
  import parking_pkg::*;
#(
  parameter int unsigned OPEN_CYCLES  = DEF_OPEN_CYCLES,
  parameter int unsigned PASS_TIMEOUT = DEF_PASS_TIMEOUT,
  parameter int unsigned CLOSE_CYCLES = DEF_CLOSE_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic normal_req,
  input  logic handicap_req,
  input  logic normal_avail,
  input  logic handicap_avail,
  input  logic car_passed,
  output logic gate_open,
  output logic normal_commit,
  output logic handicap_commit,
  output logic reject,
  output logic abort,
  output logic busy
);

  localparam logic [CNT_W-1:0] OPEN_LIM  = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] PASS_LIM  = CNT_W'(PASS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CLOSE_LIM = CNT_W'(CLOSE_CYCLES - 1);

  gate_state_t      state, state_d;
  lane_t            last_served, last_served_d, pick;
  logic             pend_n, pend_h, clr_n, clr_h;
  logic             elig_n, elig_h;
  logic             tmr_clear, tmr_en, tmr_done;
  logic [CNT_W-1:0] tmr_limit;
  logic             normal_commit_d, handicap_commit_d, reject_d, abort_d;

  assign elig_n = pend_n & normal_avail;
  assign elig_h = pend_h & handicap_avail;

  gate_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .limit  (tmr_limit),
    .done   (tmr_done)
  );

  // last_served also names the lane currently being admitted
  always_comb begin
    state_d           = state;
    last_served_d     = last_served;
    pick              = other_lane(last_served);
    clr_n             = 1'b0;
    clr_h             = 1'b0;
    tmr_clear         = 1'b0;
    tmr_en            = 1'b0;
    tmr_limit         = '0;
    normal_commit_d   = 1'b0;
    handicap_commit_d = 1'b0;
    reject_d          = 1'b0;
    abort_d           = 1'b0;
    case (state)
      IDLE: begin
        tmr_clear = 1'b1;
        clr_n     = pend_n & ~normal_avail;
        clr_h     = pend_h & ~handicap_avail;
        reject_d  = clr_n | clr_h;
        if (elig_n || elig_h) begin
          if (!(elig_n && elig_h)) begin
            pick = elig_h ? LANE_HANDICAP : LANE_NORMAL;
          end
          last_served_d = pick;
          if (pick == LANE_HANDICAP) begin
            clr_h = 1'b1;
          end else begin
            clr_n = 1'b1;
          end
          state_d = OPEN;
        end
      end
      OPEN: begin
        tmr_limit = OPEN_LIM;
        if (tmr_done) begin
          tmr_clear = 1'b1;
          state_d   = WAIT_PASS;
        end else begin
          tmr_en = 1'b1;
        end
      end
      WAIT_PASS: begin
        tmr_limit = PASS_LIM;
        if (car_passed) begin
          normal_commit_d   = (last_served == LANE_NORMAL);
          handicap_commit_d = (last_served == LANE_HANDICAP);
          tmr_clear         = 1'b1;
          state_d           = CLOSE;
        end else if (tmr_done) begin
          abort_d   = 1'b1;
          tmr_clear = 1'b1;
          state_d   = CLOSE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      CLOSE: begin
        tmr_limit = CLOSE_LIM;
        if (tmr_done) begin
          tmr_clear = 1'b1;
          state_d   = IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // request set wins over selection clear, so a coinciding pulse stays queued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      last_served     <= LANE_NORMAL;
      pend_n          <= 1'b0;
      pend_h          <= 1'b0;
      gate_open       <= 1'b0;
      busy            <= 1'b0;
      normal_commit   <= 1'b0;
      handicap_commit <= 1'b0;
      reject          <= 1'b0;
      abort           <= 1'b0;
    end else begin
      state           <= state_d;
      last_served     <= last_served_d;
      pend_n          <= (pend_n & ~clr_n) | normal_req;
      pend_h          <= (pend_h & ~clr_h) | handicap_req;
      gate_open       <= (state_d == OPEN) || (state_d == WAIT_PASS);
      busy            <= (state_d != IDLE);
      normal_commit   <= normal_commit_d;
      handicap_commit <= handicap_commit_d;
      reject          <= reject_d;
      abort           <= abort_d;
    end
  end

endmodule

// File: tb/tb_gate_arbiter.sv
// tb/tb_gate_arbiter.sv - self-checking bench for gate_arbiter
module tb_gate_arbiter;

  localparam int O = 4;
  localparam int T = 10;
  localparam int C = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic normal_req = 1'b0, handicap_req = 1'b0;
  logic normal_avail = 1'b1, handicap_avail = 1'b1;
  logic car_passed = 1'b0;
  logic gate_open, normal_commit, handicap_commit, reject, abort, busy;

  always #5 clk = ~clk;

  gate_arbiter #(
    .OPEN_CYCLES  (O),
    .PASS_TIMEOUT (T),
    .CLOSE_CYCLES (C),
    .CNT_W        (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .normal_req      (normal_req),
    .handicap_req    (handicap_req),
    .normal_avail    (normal_avail),
    .handicap_avail  (handicap_avail),
    .car_passed      (car_passed),
    .gate_open       (gate_open),
    .normal_commit   (normal_commit),
    .handicap_commit (handicap_commit),
    .reject          (reject),
    .abort           (abort),
    .busy            (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // output order: {gate_open, normal_commit, handicap_commit, reject, abort, busy}
  function automatic logic [5:0] outs();
    return {gate_open, normal_commit, handicap_commit, reject, abort, busy};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    normal_req = 1'b0; handicap_req = 1'b0; car_passed = 1'b0;
    normal_avail = 1'b1; handicap_avail = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", outs(), 6'b000000);
    reset = 1'b1;
  endtask

  // ---------------- hand-sequence accumulators ----------------
  int tcyc, n_nc, n_hc, n_ab, n_busy, n_both, cyc_ab, last_busy;
  int order[$];

  task automatic clear_acc();
    tcyc = 0; n_nc = 0; n_hc = 0; n_ab = 0; n_busy = 0; n_both = 0;
    cyc_ab = -1; last_busy = -1;
    order.delete();
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(negedge clk);
      tcyc++;
      if (normal_commit) begin n_nc++; order.push_back(0); end
      if (handicap_commit) begin n_hc++; order.push_back(1); end
      if (normal_commit && handicap_commit) n_both++;
      if (abort) begin n_ab++; cyc_ab = tcyc; end
      if (busy) begin n_busy++; last_busy = tcyc; end
    end
  endtask

  task automatic pulse(logic n, logic h);
    normal_req = n; handicap_req = h;
    run(1);
    normal_req = 1'b0; handicap_req = 1'b0;
  endtask

  // ---------------- reference model (timestamp based) ----------------
  bit m_pn, m_ph, m_idle, m_last_h, m_lane_h;
  int m_adm, m_close, m_cyc;
  logic [5:0] m_exp;

  task automatic model_init();
    m_pn = 0; m_ph = 0; m_idle = 1; m_last_h = 0; m_lane_h = 0;
    m_adm = 0; m_close = 0; m_cyc = 0; m_exp = '0;
  endtask

  // Given this cycle's inputs, predict outputs seen in the next cycle.
  // An admission chosen at cycle a opens during a+1..a+O, waits during
  // a+O+1..a+O+T, and closes for C cycles starting the cycle after pass/timeout.
  task automatic model_step(bit nr, bit hr, bit na, bit ha, bit car);
    bit rej, ab, cn, ch, pick_h;
    rej = 0; ab = 0; cn = 0; ch = 0;
    if (m_idle) begin
      rej = (m_pn && !na) || (m_ph && !ha);
      if (!na) m_pn = 0;
      if (!ha) m_ph = 0;
      if (m_pn || m_ph) begin
        pick_h = (m_pn && m_ph) ? !m_last_h : m_ph;
        if (pick_h) m_ph = 0; else m_pn = 0;
        m_lane_h = pick_h; m_last_h = pick_h;
        m_idle = 0; m_adm = m_cyc; m_close = -1;
      end
    end else if (m_close < 0) begin
      if (m_cyc > m_adm + O && car) begin
        cn = !m_lane_h; ch = m_lane_h; m_close = m_cyc + 1;
      end else if (m_cyc == m_adm + O + T) begin
        ab = 1; m_close = m_cyc + 1;
      end
    end else if (m_cyc == m_close + C - 1) begin
      m_idle = 1;
    end
    m_pn = m_pn | nr;
    m_ph = m_ph | hr;
    m_exp = {(!m_idle && m_close < 0), cn, ch, rej, ab, !m_idle};
    m_cyc++;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [4:0] in;   // {normal_req, handicap_req, normal_avail, handicap_avail, car_passed}
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // single handicap admission with car, then a normal reject
    tbl[0]  = {5'b01110, 6'b000000};
    tbl[1]  = {5'b00110, 6'b100001};
    tbl[2]  = {5'b00110, 6'b100001};
    tbl[3]  = {5'b00110, 6'b100001};
    tbl[4]  = {5'b00110, 6'b100001};
    tbl[5]  = {5'b00111, 6'b100001};
    tbl[6]  = {5'b00111, 6'b001001};
    tbl[7]  = {5'b00111, 6'b000001};
    tbl[8]  = {5'b00110, 6'b000001};
    tbl[9]  = {5'b00110, 6'b000000};
    tbl[10] = {5'b10010, 6'b000000};
    tbl[11] = {5'b00010, 6'b000100};
    tbl[12] = {5'b00010, 6'b000000};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      {normal_req, handicap_req, normal_avail, handicap_avail, car_passed} = tbl[i].in;
      @(negedge clk);
      chk($sformatf("table_row%0d", i), outs(), tbl[i].exp);
    end

    // tie after reset goes to handicap; a second pair during that admission lets normal go next
    do_reset(); clear_acc();
    car_passed = 1'b1;
    pulse(1'b1, 1'b1);
    run(2);
    pulse(1'b1, 1'b1);
    run(60);
    begin
      int code = 0;
      foreach (order[i]) code = code * 2 + order[i];
      chk("tie_commit_count", order.size(), 3);
      chk("tie_order_h_n_h", code, 5);
      chk("tie_never_both", n_both, 0);
    end

    // no car: abort after the full wait window, then close
    do_reset(); clear_acc();
    car_passed = 1'b0;
    pulse(1'b0, 1'b1);
    run(40);
    chk("timeout_abort_count", n_ab, 1);
    chk("timeout_abort_cycle", cyc_ab, 2 + O + T);
    chk("timeout_no_commit", n_nc + n_hc, 0);
    chk("timeout_last_busy", last_busy, 1 + O + T + C);

    // repeated requests during one admission queue only one more
    do_reset(); clear_acc();
    car_passed = 1'b1;
    pulse(1'b1, 1'b0);
    run(2);
    pulse(1'b1, 1'b0);
    run(1);
    pulse(1'b1, 1'b0);
    run(1);
    pulse(1'b1, 1'b0);
    run(60);
    chk("queue_normal_commits", n_nc, 2);
    chk("queue_handicap_commits", n_hc, 0);

    // asynchronous reset during WAIT_PASS
    do_reset(); clear_acc();
    car_passed = 1'b0;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    run(5);
    chk("areset_gate_before", gate_open, 1'b1);
    #2 reset = 1'b0;
    #1 chk("areset_outputs_now", outs(), 6'b000000);
    @(negedge clk);
    reset = 1'b1;
    car_passed = 1'b1;
    clear_acc();
    run(30);
    chk("areset_no_events", n_nc + n_hc + n_ab, 0);
    chk("areset_stays_idle", n_busy, 0);
    pulse(1'b1, 1'b0);
    run(14);
    chk("areset_new_request", n_nc, 1);

    // randomized stimulus against the reference model
    do_reset();
    model_init();
    for (int i = 0; i < 2000; i++) begin
      bit nr, hr, na, ha, car;
      nr  = ($urandom_range(0, 5) == 0);
      hr  = ($urandom_range(0, 5) == 0);
      na  = ($urandom_range(0, 4) != 0);
      ha  = ($urandom_range(0, 4) != 0);
      car = ($urandom_range(0, 7) == 0);
      {normal_req, handicap_req, normal_avail, handicap_avail, car_passed} = {nr, hr, na, ha, car};
      model_step(nr, hr, na, ha, car);
      @(negedge clk);
      chk($sformatf("random_cycle%0d", i), outs(), m_exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
